// File: rtl/fifo2axis.sv
// fifo2axis: drains a synchronous packet FIFO into an AXI4-Stream,
// unpacking each wide word MSB slice first and regenerating frame markers.
module fifo2axis #(
    parameter int FAW             = 8,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int PKT_BEATS       = 16
) (
    input  logic                           S_AXIS_ACLK,
    input  logic                           S_AXIS_ARESETN,
    input  logic                           en,
    input  logic                           frd_empty,
    input  logic [FAW:0]                   frd_cnt,
    output logic                           frd_en,
    input  logic [AXI4_DATA_WIDTH-1:0]     frd_dat,
    output logic                           M_AXIS_TVALID,
    output logic [AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                           M_AXIS_TLAST,
    output logic                           M_AXIS_USER,
    input  logic                           M_AXIS_TREADY,
    output logic [15:0]                    frame_cnt
);
    localparam int R  = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int KW = (R > 1) ? $clog2(R) : 1;
    localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(R - 1);
    localparam logic [BW-1:0] B_LAST = BW'(PKT_BEATS - 1);

    logic [AXI4_DATA_WIDTH-1:0] out_q, out_d;
    logic [AXI4_DATA_WIDTH-1:0] hold_q, hold_d;
    logic                       out_vld_q, out_vld_d;
    logic                       hold_vld_q, hold_vld_d;
    logic                       rd_pend_q, rd_pend_d;
    logic [KW-1:0]              k_q, k_d;
    logic [BW-1:0]              b_q, b_d;
    logic [15:0]                frame_q, frame_d;

    logic [1:0]                 occ;
    logic                       xfer;
    logic                       pop;
    logic                       out_free;
    logic [31:0]                shamt;
    logic [AXI4_DATA_WIDTH-1:0] shifted;
    logic                       unused_cnt;

    // Fill count is informational only; flow control uses frd_empty.
    assign unused_cnt = ^frd_cnt;

    assign occ = {1'b0, out_vld_q} + {1'b0, hold_vld_q} + {1'b0, rd_pend_q};
    assign xfer     = out_vld_q & M_AXIS_TREADY;
    assign pop      = xfer & (k_q == K_LAST);
    assign out_free = ~out_vld_q | pop;

    assign frd_en = en & ~frd_empty &
                    ((occ < 2'd2) | ((occ == 2'd2) & pop));

    always_comb begin
        out_d      = out_q;
        hold_d     = hold_q;
        out_vld_d  = out_vld_q;
        hold_vld_d = hold_vld_q;
        k_d        = k_q;
        b_d        = b_q;
        frame_d    = frame_q;
        rd_pend_d  = frd_en;

        // Hold is older than any returning word, so it drains first.
        if (out_free) begin
            k_d = '0;
            if (hold_vld_q) begin
                out_d      = hold_q;
                out_vld_d  = 1'b1;
                hold_vld_d = rd_pend_q;
                if (rd_pend_q) begin
                    hold_d = frd_dat;
                end
            end else if (rd_pend_q) begin
                out_d     = frd_dat;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else begin
            if (xfer) begin
                k_d = k_q + KW'(1);
            end
            if (rd_pend_q) begin
                hold_d     = frd_dat;
                hold_vld_d = 1'b1;
            end
        end

        if (xfer) begin
            if (b_q == B_LAST) begin
                b_d     = '0;
                frame_d = frame_q + 16'd1;
            end else begin
                b_d = b_q + BW'(1);
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            out_q      <= '0;
            hold_q     <= '0;
            out_vld_q  <= 1'b0;
            hold_vld_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            k_q        <= '0;
            b_q        <= '0;
            frame_q    <= '0;
        end else begin
            out_q      <= out_d;
            hold_q     <= hold_d;
            out_vld_q  <= out_vld_d;
            hold_vld_q <= hold_vld_d;
            rd_pend_q  <= rd_pend_d;
            k_q        <= k_d;
            b_q        <= b_d;
            frame_q    <= frame_d;
        end
    end

    assign shamt   = 32'(k_q) * 32'(AXIS_DATA_WIDTH);
    assign shifted = out_q << shamt;

    assign M_AXIS_TVALID = out_vld_q;
    assign M_AXIS_TDATA  = out_vld_q ?
                           shifted[AXI4_DATA_WIDTH-1 -: AXIS_DATA_WIDTH] : '0;
    assign M_AXIS_TSTRB  = {(AXIS_DATA_WIDTH/8){out_vld_q}};
    assign M_AXIS_USER   = out_vld_q & (b_q == '0);
    assign M_AXIS_TLAST  = out_vld_q & (b_q == B_LAST);
    assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_fifo2axis.sv
// Bench for fifo2axis: a 64->32 instance checked by a queue scoreboard,
// plus a 32->32 instance checked cycle by cycle for latency.
module tb_fifo2axis;
    localparam int AW  = 64;
    localparam int SW  = 32;
    localparam int R   = 2;
    localparam int PKT = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Wide instance
    logic          en, empty, frd_en, tvalid, tlast, tuser, tready;
    logic [AW-1:0] frd_dat;
    logic [SW-1:0] tdata;
    logic [3:0]    tstrb;
    logic [15:0]   fcnt;
    logic [8:0]    fill;
    logic [AW-1:0] mem [0:255];
    int            wp = 0;
    int            rp = 0;
    int            rd_n = 0;

    assign empty = (wp == rp);
    assign fill  = 9'(wp - rp);

    fifo2axis #(
        .FAW(8), .AXIS_DATA_WIDTH(SW), .AXI4_DATA_WIDTH(AW), .PKT_BEATS(PKT)
    ) dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .en(en),
        .frd_empty(empty), .frd_cnt(fill), .frd_en(frd_en),
        .frd_dat(frd_dat), .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata),
        .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast), .M_AXIS_USER(tuser),
        .M_AXIS_TREADY(tready), .frame_cnt(fcnt)
    );

    always @(posedge clk) begin
        if (frd_en) begin
            frd_dat <= mem[rp[7:0]];
            rp      <= rp + 1;
        end
        if (!rst_n) rd_n <= 0;
        else if (frd_en) rd_n <= rd_n + 1;
    end

    // Narrow instance, R=1, PKT_BEATS=4
    logic        en1, empty1, frd_en1, tvalid1, tlast1, tuser1;
    logic [31:0] frd_dat1, tdata1;
    logic [3:0]  tstrb1;
    logic [15:0] fcnt1;
    logic [8:0]  fill1;
    logic [31:0] mem1 [0:15];
    int          wp1 = 0;
    int          rp1 = 0;

    assign empty1 = (wp1 == rp1);
    assign fill1  = 9'(wp1 - rp1);

    fifo2axis #(
        .FAW(8), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(32), .PKT_BEATS(4)
    ) dut1 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .en(en1),
        .frd_empty(empty1), .frd_cnt(fill1), .frd_en(frd_en1),
        .frd_dat(frd_dat1), .M_AXIS_TVALID(tvalid1), .M_AXIS_TDATA(tdata1),
        .M_AXIS_TSTRB(tstrb1), .M_AXIS_TLAST(tlast1), .M_AXIS_USER(tuser1),
        .M_AXIS_TREADY(1'b1), .frame_cnt(fcnt1)
    );

    always @(posedge clk) begin
        if (frd_en1) begin
            frd_dat1 <= mem1[rp1[3:0]];
            rp1      <= rp1 + 1;
        end
    end

    typedef struct packed {
        logic [SW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t expq[$];
    int    eb = 0;
    int    nbeats = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] w);
        mem[wp[7:0]] = w;
        wp = wp + 1;
        for (int s = 0; s < R; s++) begin
            beat_t e;
            e.d = w[AW-1-s*SW -: SW];
            e.u = (eb == 0);
            e.l = (eb == PKT - 1);
            expq.push_back(e);
            eb = (eb + 1) % PKT;
        end
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while ((expq.size() != 0 || tvalid) && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats left, expected 0",
                     expq.size());
        end
    endtask

    task automatic wait_beats(input int target, input int lim);
        int n = 0;
        while (nbeats < target && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (nbeats < target) begin
            errors++;
            $display("FAIL beat_timeout: got %0d beats expected %0d",
                     nbeats, target);
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        @(negedge clk);
        while (!tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tvalid) begin
            errors++;
            $display("FAIL %s: tvalid got 0 expected 1", nm);
        end
    endtask

    // Scoreboard monitor and handshake/occupancy checker
    initial begin
        int    slice = 0;
        int    pop_n = 0;
        int    occ;
        logic  popnow;
        logic  stall_q = 1'b0;
        beat_t prev;
        beat_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
                slice   = 0;
                pop_n   = 0;
                stall_q = 1'b0;
            end else begin
                occ    = rd_n - pop_n;
                popnow = tvalid & tready & (slice == R - 1);
                checks++;
                if (occ > 3 || (frd_en && !(occ < 2 || (occ == 2 && popnow)))) begin
                    errors++;
                    $display("FAIL occ_rule: occ %0d frd_en %0b pop %0b",
                             occ, frd_en, popnow);
                end
                if (frd_en) begin
                    checks++;
                    if (empty) begin
                        errors++;
                        $display("FAIL read_empty: frd_en 1 with empty 1, expected 0");
                    end
                end
                checks++;
                if (tstrb !== (tvalid ? 4'hF : 4'h0)) begin
                    errors++;
                    $display("FAIL tstrb: got %0h with tvalid %0b", tstrb, tvalid);
                end
                if (stall_q) begin
                    checks++;
                    if (!tvalid || tdata !== prev.d || tuser !== prev.u ||
                        tlast !== prev.l) begin
                        errors++;
                        $display("FAIL stall_hold: got v%0b %0h u%0b l%0b expected v1 %0h u%0b l%0b",
                                 tvalid, tdata, tuser, tlast, prev.d, prev.u, prev.l);
                    end
                end
                if (tvalid && tready) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got %0h expected none", tdata);
                    end else begin
                        e = expq.pop_front();
                        if (tdata !== e.d || tuser !== e.u || tlast !== e.l) begin
                            errors++;
                            $display("FAIL beat: got %0h u%0b l%0b expected %0h u%0b l%0b",
                                     tdata, tuser, tlast, e.d, e.u, e.l);
                        end
                    end
                    nbeats++;
                    if (popnow) pop_n++;
                    slice = (slice + 1) % R;
                end
                stall_q = tvalid & ~tready;
                prev.d  = tdata;
                prev.u  = tuser;
                prev.l  = tlast;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] e_en;
        logic [6:0] e_v;
        int         base;
        e_en   = 7'b0001111;
        e_v    = 7'b0111100;
        en     = 1'b0;
        en1    = 1'b0;
        tready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tstrb", tstrb, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_user", tuser, 0);
        chk("rst_frd_en", frd_en, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_tvalid1", tvalid1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R=1 latency and framing, cycle accurate
        mem1[0] = 32'h11;
        mem1[1] = 32'h22;
        mem1[2] = 32'h33;
        mem1[3] = 32'h44;
        wp1 = 4;
        en1 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("r1_frd_en_c%0d", c), frd_en1, e_en[c]);
            chk($sformatf("r1_tvalid_c%0d", c), tvalid1, e_v[c]);
            if (e_v[c]) begin
                chk($sformatf("r1_tdata_c%0d", c), tdata1, 32'h11 * (c - 1));
                chk($sformatf("r1_user_c%0d", c), tuser1, c == 2);
                chk($sformatf("r1_tlast_c%0d", c), tlast1, c == 5);
                chk($sformatf("r1_tstrb_c%0d", c), tstrb1, 4'hF);
            end
            tick();
        end
        chk("r1_frame_cnt", fcnt1, 1);

        // Eight words streamed back to back
        push(64'hAAAA0001_BBBB0002);
        for (int i = 1; i < 8; i++)
            push({32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)});
        tready = 1'b1;
        en     = 1'b1;
        wait_valid("first_valid");
        chk("beat0_data", tdata, 32'hAAAA0001);
        chk("beat0_user", tuser, 1);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("no_gap_%0d", i), tvalid, 1);
            if (i == 1) chk("beat1_data", tdata, 32'hBBBB0002);
        end
        tick();
        wait_drain(40);
        chk("frames_a", fcnt, 3);

        // Backpressure for 5 cycles on the third beat
        base = nbeats;
        for (int i = 0; i < 4; i++)
            push({32'hE000_0000 + 32'(i), 32'hF000_0000 + 32'(i)});
        wait_beats(base + 2, 20);
        tready = 1'b0;
        repeat (5) tick();
        tready = 1'b1;
        wait_drain(50);

        // FIFO empty mid-frame: nothing read, nothing presented
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_frd_en_%0d", i), frd_en, 0);
            chk($sformatf("idle_tvalid_%0d", i), tvalid, 0);
        end
        tick();
        push(64'h1111_2222_3333_4444);
        push(64'h5555_6666_7777_8888);
        push(64'h9999_AAAA_BBBB_CCCC);
        wait_valid("refill_valid");
        chk("refill_tlast", tlast, 1);
        chk("refill_user", tuser, 0);
        chk("refill_data", tdata, 32'h1111_2222);
        @(negedge clk);
        chk("refill_user2", tuser, 1);
        chk("refill_data2", tdata, 32'h3333_4444);
        tick();
        wait_drain(40);

        // en low with FIFO non-empty
        for (int i = 0; i < 6; i++)
            push({32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i)});
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("en0_frd_en_%0d", i), frd_en, 0);
        end
        chk("en0_drained", tvalid, 0);
        chk("en0_fifo_left", empty, 0);
        tick();
        en = 1'b1;
        wait_drain(60);
        chk("frames_total", fcnt, 8);
        chk("fifo_empty_end", empty, 1);

        // Reset with a read in flight and the output register loaded
        tready = 1'b0;
        push(64'hDEAD_0001_DEAD_0002);
        push(64'hBEEF_0003_BEEF_0004);
        tick();
        tick();
        @(negedge clk);
        chk("pre_rst_tvalid", tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_tstrb", tstrb, 0);
        chk("mid_rst_user", tuser, 0);
        chk("mid_rst_tlast", tlast, 0);
        chk("mid_rst_fcnt", fcnt, 0);
        eb = 0;
        tick();
        tick();
        tready = 1'b1;
        rst_n  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_tvalid_%0d", i), tvalid, 0);
        end
        chk("post_rst_fcnt", fcnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
